// File: rtl/somador4bits.sv
`default_nettype none
// ============================================================================
// Module   : somador4bits
// Purpose  : Registered unsigned ripple-carry adder; WIDTH+1-bit sum with
//            the carry-out in the MSB, presented one clock after capture.
//            Optional signed-overflow flag built when SOMADOR_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module somador4bits #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH:0]   resultado,
    output logic             out_valid
`ifdef SOMADOR_OVF_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   r_resultado;
    logic             r_out_valid;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_full_adder
            logic w_half;
            assign w_half          = num1[gi] ^ num2[gi];
            assign w_sum[gi]       = w_half ^ w_carry[gi];
            assign w_carry[gi + 1] = (num1[gi] & num2[gi]) | (w_carry[gi] & w_half);
        end
    endgenerate

    // Reset outranks a capture in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resultado <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_resultado <= {w_carry[WIDTH], w_sum};
            end
        end
    end

    assign resultado = r_resultado;
    assign out_valid = r_out_valid;

`ifdef SOMADOR_OVF_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid) begin
            r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_somador4bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_somador4bits
// Purpose  : Directed self-checking bench for somador4bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_somador4bits;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [4:0] resultado;
    logic       out_valid;
`ifdef SOMADOR_OVF_EN
    logic       overflow;
`endif

    int n_tests;
    int n_fail;

    somador4bits #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .resultado (resultado),
        .out_valid (out_valid)
`ifdef SOMADOR_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        num1     = 4'hF;
        num2     = 4'hF;

        // Reset with a pending capture must still clear the outputs.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'hF, 4'hF);
            chk("reset_resultado", resultado, 5'b00000);
            chk("reset_out_valid", {4'b0, out_valid}, 5'd0);
`ifdef SOMADOR_OVF_EN
            chk("reset_overflow", {4'b0, overflow}, 5'd0);
`endif
        end

        // Directed cases with hand-computed sums.
        step(1'b0, 1'b1, 4'h3, 4'h5);
        chk("3+5", resultado, 5'b01000);
        chk("3+5_valid", {4'b0, out_valid}, 5'd1);
        step(1'b0, 1'b1, 4'hF, 4'h1);
        chk("F+1", resultado, 5'b10000);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        chk("F+F", resultado, 5'b11110);
        step(1'b0, 1'b1, 4'h0, 4'h0);
        chk("0+0", resultado, 5'b00000);
        chk("0+0_valid", {4'b0, out_valid}, 5'd1);

        // Exhaustive sweep, back-to-back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(1'b0, 1'b1, 4'(a), 4'(b));
                chk("sweep_sum", resultado, 5'(a + b));
                chk("sweep_valid", {4'b0, out_valid}, 5'd1);
            end
        end

        // Hold: idle cycles with junk on the operands.
        step(1'b0, 1'b1, 4'h7, 4'h2);
        chk("7+2", resultado, 5'b01001);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
            chk("hold_resultado", resultado, 5'b01001);
            chk("hold_out_valid", {4'b0, out_valid}, 5'd0);
        end
        step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
        chk("hold_x_resultado", resultado, 5'b01001);

        // Reset in the middle of a stream.
        step(1'b0, 1'b1, 4'h1, 4'h2);
        chk("stream1", resultado, 5'd3);
        step(1'b0, 1'b1, 4'h4, 4'h4);
        chk("stream2", resultado, 5'd8);
        step(1'b1, 1'b1, 4'h9, 4'h9);
        chk("midrst_resultado", resultado, 5'd0);
        chk("midrst_out_valid", {4'b0, out_valid}, 5'd0);
        step(1'b0, 1'b1, 4'hA, 4'h6);
        chk("resume", resultado, 5'b10000);
        chk("resume_valid", {4'b0, out_valid}, 5'd1);

`ifdef SOMADOR_OVF_EN
        step(1'b0, 1'b1, 4'h7, 4'h1);
        chk("ovf_7+1", {4'b0, overflow}, 5'd1);
        step(1'b0, 1'b1, 4'h3, 4'h2);
        chk("ovf_3+2", {4'b0, overflow}, 5'd0);
        step(1'b0, 1'b1, 4'h8, 4'h8);
        chk("ovf_8+8", {4'b0, overflow}, 5'd1);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        chk("ovf_hold", {4'b0, overflow}, 5'd1);
`endif

        step(1'b0, 1'b0, 4'h0, 4'h0);
        chk("final_idle_valid", {4'b0, out_valid}, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
